// File: rtl/lc3b_types.sv
// Core-wide LC-3b types and constants shared by the pipeline stages.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Instruction-fetch controller states
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    // Default fetch parameters for core-wide use
    localparam lc3b_word LC3B_RESET_PC = 16'h0000;
    localparam lc3b_word LC3B_PC_STEP  = 16'd2;

endpackage

// File: rtl/if_fetch.sv
// LC-3b instruction-fetch stage: owns the PC, reads instruction memory and
// hands {pc, instr} plus an advance strobe to the IF/ID register. Honours
// downstream stall and redirect, and squashes a fetch made stale by a redirect.
module if_fetch
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = LC3B_RESET_PC,
    parameter lc3b_word PC_STEP  = LC3B_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic [15:0] pc_out,
    output logic [15:0] instr_out,
    output logic        advance
);

    fetch_state_t state_q, state_d;
    lc3b_word     pc_q, pc_d;
    lc3b_word     held_q, held_d;
    lc3b_word     target_q, target_d;
    lc3b_word     redir_pc;
    lc3b_word     pc_inc;

    // Instructions are word aligned, so the redirect target's low bit is dropped
    assign redir_pc = redirect_pc & 16'hFFFE;
    assign pc_inc   = pc_q + PC_STEP;

    // State register, PC, held instruction and squash target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            held_q   <= 16'h0000;
            target_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            held_q   <= held_d;
            target_q <= target_d;
        end
    end

    // Next-state and next-PC selection; redirect outranks stall
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        held_d   = held_q;
        target_d = target_q;
        unique case (state_q)
            FETCH: begin
                if (imem_resp) begin
                    if (redirect) begin
                        pc_d = redir_pc;
                    end else if (!stall) begin
                        pc_d = pc_inc;
                    end else begin
                        held_d  = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (redirect) begin
                    // Read in flight cannot be retargeted; remember where to go
                    target_d = redir_pc;
                    state_d  = SQUASH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redir_pc;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            SQUASH: begin
                if (imem_resp) begin
                    pc_d    = redirect ? redir_pc : target_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    target_d = redir_pc;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Memory request and IF/ID outputs; everything quiet while in reset
    always_comb begin
        imem_read    = 1'b0;
        imem_address = pc_q;
        pc_out       = pc_q;
        instr_out    = held_q;
        advance      = 1'b0;
        if (!rst_n) begin
            instr_out = 16'h0000;
        end else begin
            unique case (state_q)
                FETCH: begin
                    imem_read = 1'b1;
                    if (imem_resp) begin
                        instr_out = imem_rdata;
                        advance   = !redirect && !stall;
                    end
                end
                HOLD: begin
                    advance = !redirect && !stall;
                end
                SQUASH: begin
                    imem_read = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: the initial block plays instruction memory and
// control inputs; every expected IF/ID transfer is queued up front and the
// advance monitor pops and compares it.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic [15:0] pc_out;
    logic [15:0] instr_out;
    logic        advance;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_chk = 0;
    int    n_err = 0;

    if_fetch #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .advance      (advance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory read lasting lat cycles; address must be stable the whole time
    task automatic mem_read(input int lat, input logic [15:0] addr, input logic [15:0] data);
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            chk("wait_read", {15'd0, imem_read}, 16'd1);
            chk("wait_addr", imem_address, addr);
            step();
        end
        imem_resp  = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        chk("resp_read", {15'd0, imem_read}, 16'd1);
        chk("resp_addr", imem_address, addr);
        step();
        imem_resp  = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    task automatic expect_xfer(input logic [15:0] pc, input logic [15:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    // Scoreboard: every advance must match the oldest queued transfer
    always @(negedge clk) begin
        if (advance) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_advance", pc_out, 16'hxxxx);
            end else begin
                xfer_t e;
                e = exp_q.pop_front();
                chk("adv_pc", pc_out, e.pc);
                chk("adv_instr", instr_out, e.instr);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_rdata  = 16'h0000;
        imem_resp   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_read", {15'd0, imem_read}, 16'd0);
        chk("rst_adv", {15'd0, advance}, 16'd0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_instr", instr_out, 16'h0000);
        step();
        rst_n = 1'b1;

        // Sequential fetch 0000, 0002, 0004
        expect_xfer(16'h0000, 16'h1111); mem_read(2, 16'h0000, 16'h1111);
        expect_xfer(16'h0002, 16'h2222); mem_read(2, 16'h0002, 16'h2222);
        expect_xfer(16'h0004, 16'h3333); mem_read(2, 16'h0004, 16'h3333);

        // Stall at response -> HOLD for 3 cycles, then release
        stall = 1'b1;
        mem_read(2, 16'h0006, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_read", {15'd0, imem_read}, 16'd0);
            chk("hold_instr", instr_out, 16'h1234);
            chk("hold_pc", pc_out, 16'h0006);
            step();
        end
        expect_xfer(16'h0006, 16'h1234);
        stall = 1'b0;
        step();
        expect_xfer(16'h0008, 16'h4444); mem_read(2, 16'h0008, 16'h4444);

        // Redirect while holding: held instruction dropped, odd target aligned
        stall = 1'b1;
        mem_read(2, 16'h000A, 16'hABCD);
        redirect    = 1'b1;
        redirect_pc = 16'h3001;
        @(negedge clk);
        chk("hold_redir_adv", {15'd0, advance}, 16'd0);
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        expect_xfer(16'h3000, 16'h5555); mem_read(2, 16'h3000, 16'h5555);

        // Redirect mid-read: address held until the late response, data dropped
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        mem_read(4, 16'h3002, 16'hDEAD);
        expect_xfer(16'h0100, 16'h6666); mem_read(2, 16'h0100, 16'h6666);

        // Second redirect in SQUASH coinciding with the response wins
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect_pc = 16'h0200;
        mem_read(1, 16'h0102, 16'hBEEF);
        redirect = 1'b0;
        expect_xfer(16'h0200, 16'h7777); mem_read(2, 16'h0200, 16'h7777);

        // Redirect together with response in FETCH, then PC wrap at FFFE
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        mem_read(1, 16'h0202, 16'hBAD0);
        redirect = 1'b0;
        expect_xfer(16'hFFFE, 16'h8888); mem_read(2, 16'hFFFE, 16'h8888);
        expect_xfer(16'h0000, 16'h9999); mem_read(2, 16'h0000, 16'h9999);

        // Asynchronous reset in the middle of a read
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_read", {15'd0, imem_read}, 16'd0);
        chk("async_rst_pc", pc_out, 16'h0000);
        chk("async_rst_adv", {15'd0, advance}, 16'd0);
        step();
        rst_n = 1'b1;
        expect_xfer(16'h0000, 16'hCAFE); mem_read(2, 16'h0000, 16'hCAFE);

        // Every queued transfer must have been delivered
        repeat (2) step();
        chk("queue_left", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
